// File: rtl/kmeans_centroid_update.sv
// k-means centroid update stage.
// Accumulates per-cluster sums and counts over one pass of tagged points,
// then divides sum/count for every cluster with one shared restoring
// divider (one quotient bit per cycle) and streams the K new centroids out.
//
// Handshake: a point is taken on any rising edge where in_valid=1 and
// busy=0. There is no backpressure on the output side: out_valid is a
// one-cycle qualifier, and out_data/out_cid hold their value while it is low.
module kmeans_centroid_update #(
  parameter int K      = 4,
  parameter int N      = 4096,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 13,
  parameter int SUM_W  = 28,
  localparam int CID_W = (K > 1) ? $clog2(K) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CID_W-1:0]  in_cid,
  input  logic              in_last,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CID_W-1:0]  out_cid,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int BIT_W = $clog2(SUM_W);
  localparam int IDX_W = CID_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DIV  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Accumulators
  logic [SUM_W-1:0]  sum_q  [K];
  logic [CNT_W-1:0]  cnt_q  [K];
  logic [CNT_W-1:0]  total_q;
  logic              err_q;

  // Divider and centroid storage
  logic [DATA_W-1:0] cent_q [K];
  logic [CID_W-1:0]  slot_q;
  logic [BIT_W-1:0]  bit_q;
  logic [CNT_W-1:0]  rem_q;
  logic [SUM_W-1:0]  quo_q;

  // Output stream
  logic [IDX_W-1:0]  out_idx_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CID_W-1:0]  out_cid_q;

  // Shared control terms
  logic accept;
  logic drop;
  logic last_bit;
  logic last_slot;
  logic out_done;

  // Divider step
  logic [SUM_W-1:0]  div_num;
  logic [CNT_W-1:0]  div_rem;
  logic [CNT_W:0]    div_shift;
  logic [CNT_W:0]    div_dvs;
  logic [CNT_W:0]    div_diff;
  logic              div_ge;
  logic [CNT_W-1:0]  rem_nxt;
  logic [SUM_W-1:0]  quo_nxt;

  // Control terms derived from the current state and counters
  always_comb begin
    accept    = in_valid && !busy;
    drop      = (total_q == CNT_W'(N));
    last_bit  = (bit_q == BIT_W'(SUM_W - 1));
    last_slot = (slot_q == CID_W'(K - 1));
    out_done  = (out_idx_q == IDX_W'(K));
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACC: if (accept) state_d = in_last ? S_DIV : S_ACC;
      S_DIV:         if (last_slot && last_bit) state_d = S_OUT;
      S_OUT:         if (out_done) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy while dividing or streaming, state exported for debug
  always_comb begin
    busy      = (state_q == S_DIV) || (state_q == S_OUT);
    dbg_state = state_q;
  end

  // Per-cluster accumulation, overflow flag, and clear after the output burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < K; k++) begin
        sum_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      total_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == S_OUT && out_done) begin
      for (int k = 0; k < K; k++) begin
        sum_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      total_q <= '0;
    end else if (accept) begin
      // First point of a pass clears the previous pass's overflow flag.
      if (state_q == S_IDLE) err_q <= drop;
      else if (drop)         err_q <= 1'b1;
      if (!drop) begin
        sum_q[in_cid] <= sum_q[in_cid] + SUM_W'(in_data);
        cnt_q[in_cid] <= cnt_q[in_cid] + CNT_W'(1);
        total_q       <= total_q + CNT_W'(1);
      end
    end
  end

  // One restoring-division step; bit 0 of each slot starts from sum[slot]
  always_comb begin
    div_num   = (bit_q == '0) ? sum_q[slot_q] : quo_q;
    div_rem   = (bit_q == '0) ? '0 : rem_q;
    div_shift = {div_rem, div_num[SUM_W-1]};
    div_dvs   = {1'b0, cnt_q[slot_q]};
    div_ge    = (div_shift >= div_dvs);
    div_diff  = div_shift - div_dvs;
    rem_nxt   = div_ge ? div_diff[CNT_W-1:0] : div_shift[CNT_W-1:0];
    quo_nxt   = {div_num[SUM_W-2:0], div_ge};
  end

  // Divider sequencing: SUM_W cycles per cluster, empty clusters keep centroid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      bit_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      for (int k = 0; k < K; k++) cent_q[k] <= '0;
    end else if (state_q == S_DIV) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      if (last_bit) begin
        bit_q  <= '0;
        slot_q <= slot_q + CID_W'(1);
        if (cnt_q[slot_q] != '0) cent_q[slot_q] <= quo_nxt[DATA_W-1:0];
      end else begin
        bit_q <= bit_q + BIT_W'(1);
      end
    end
  end

  // Output burst: K registered beats, then out_valid drops and data holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cid_q   <= '0;
    end else if (state_q == S_OUT) begin
      if (!out_done) begin
        out_valid_q <= 1'b1;
        out_cid_q   <= out_idx_q[CID_W-1:0];
        out_data_q  <= cent_q[out_idx_q[CID_W-1:0]];
        out_idx_q   <= out_idx_q + IDX_W'(1);
      end else begin
        out_valid_q <= 1'b0;
        out_idx_q   <= '0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cid   = out_cid_q;
  assign err       = err_q;

endmodule

// File: doc/kmeans_centroid_update.md
Name: kmeans_centroid_update

Overview:
- Stage directly downstream of the point-assignment stage in the k-means datapath.
- Consumes the stream of 16-bit scalar points, each tagged with its assigned cluster id. Accumulates a per-cluster sum and count.
- At the end of a pass, computes each new centroid as truncated sum/count using a shared bit-serial divider. Emits the K centroids back-to-back on a valid-qualified output bus that the memory/assignment stage loads for the next iteration.

Parameters:
- K, 4, number of clusters; power of two; CID_W = log2(K).
- N, 4096, maximum number of points per pass.
- DATA_W, 16, point/centroid width, unsigned.
- CNT_W, 13, per-cluster count width; must hold N.
- SUM_W, 28, per-cluster sum width, DATA_W + log2(N).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  point valid; one point accepted per cycle when busy=0.
- in_data  in  DATA_W  unsigned point value.
- in_cid  in  CID_W  cluster id of the point.
- in_last  in  1  qualifies the final point of a pass; sampled only with in_valid.
- busy  out  1  high in DIV and OUT; upstream must hold in_valid low.
- out_valid  out  1  centroid valid.
- out_data  out  DATA_W  new centroid value.
- out_cid  out  CID_W  cluster index of out_data, 0..K-1 in order.
- err  out  1  sticky overflow flag: more than N points in the pass.

Behaviour:
- Reset (async, rst=1): state=IDLE. All sums, counts and centroid registers = 0. busy=0, out_valid=0, out_data=0, out_cid=0, err=0.
- States: IDLE, ACC, DIV, OUT.
- IDLE/ACC accepting a point (in_valid=1):
  - sum[in_cid] += in_data; cnt[in_cid] += 1; state=ACC.
  - If in_last=1 in the same cycle, go to DIV next cycle. A single-point pass (in_last on first point) is legal.
- Total-points counter: if a point arrives when total == N, the point is dropped and err=1. err is cleared only by reset or at the start of the next pass (first accepted point after OUT).
- DIV:
  - Clusters processed k=0..K-1, each with an SUM_W-cycle restoring divide of sum[k] by cnt[k], one quotient bit per cycle.
  - The quotient is truncated toward zero. The low DATA_W bits are stored to cent[k]; the quotient never exceeds 2^DATA_W-1.
  - If cnt[k]==0, cent[k] keeps its previous value (empty cluster holds its centroid). The slot still takes SUM_W cycles, giving fixed latency.
  - busy=1 throughout.
- OUT:
  - K consecutive cycles with out_valid=1, out_cid=0..K-1, out_data=cent[out_cid].
  - Then all sums, counts and the total are cleared, state=IDLE, busy=0, out_valid=0.
  - out_data and out_cid hold their last value while out_valid=0.
- Latency: if in_last is accepted at edge T, the first out_valid=1 is visible after edge T + K*SUM_W + 1 (113 cycles at defaults). The final out_valid is at T + K*SUM_W + K.
- in_valid while busy=1: ignored, no state change; this is a protocol violation, not flagged.
- Sum width is sufficient for N points of max value, so no wrap is possible within N.
- Reset mid-DIV/OUT: immediate return to the reset state; centroid registers are also cleared.

Test Plan:
- Points 1024 (cid0), 512 (cid0, in_last) -> after 113 cycles, out_valid for 4 cycles: cid0=768, cid1..3=0; busy falls the cycle after the last output.
- Points 1024 (cid0), 512 (cid1, in_last) -> cid0=1024, cid1=512, cid2=cid3=0; err=0.
- Pass A sets cid2=100 from a single point. Pass B has no points for cid2 (cid0=7, 8, 8 with last) -> pass B output: cid0=7 (23/3 truncated), cid2=100 retained.
- 4096 points of 0xFFFF to cid3, then a 4097th point with in_last -> err=1; cid3=0xFFFF, no sum wrap.
- Assert rst for one cycle mid-DIV of a pass -> all outputs 0 immediately; a new pass with 10 (cid1, last) yields cid1=10 and all others 0.
- in_valid pulses while busy=1 with value 5000 -> outputs identical to the same pass without those pulses.
